prim_generic_ram_1r1w_scrub: RTL
================================

Name: prim_generic_ram_1r1w_scrub

Overview:
- Synchronous simple-dual-port SRAM model: one write port and one read port, both on one clock.
- Successor to the single-port generic RAM model. Adds:
  - concurrent read and write;
  - write-first forwarding when both ports hit the same address;
  - an optional output register stage and a read-valid strobe;
  - a hardware scrub (zero-fill) state machine that runs after reset or on request.
- Used for OTBN-style register files and scratch memories that must hold a known value after reset.

Parameters:
- Width, 32, data word width in bits.
- Depth, 128, number of words; need not be a power of two.
- DataBitsPerMask, 1, data bits per write-mask group; Width % DataBitsPerMask == 0, checked at elaboration.
- OutputReg, 0, 0 gives read latency 1; 1 gives read latency 2, with an extra register on rdata_o/rvalid_o.
- InitOnReset, 1, 1 means leaving reset enters SCRUB; 0 means leaving reset enters RUN with memory contents undefined (X).
- Aw, $clog2(Depth), derived localparam; minimum value 1.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- wreq_i  in  1  write request.
- waddr_i  in  Aw  write address.
- wdata_i  in  Width  write data.
- wmask_i  in  Width  full bit mask; all bits within a group must match.
- rreq_i  in  1  read request.
- raddr_i  in  Aw  read address.
- rdata_o  out  Width  read data.
- rvalid_o  out  1  one-cycle strobe marking rdata_o as new.
- scrub_req_i  in  1  start a zero-fill; level-sampled in RUN.
- scrub_busy_o  out  1  high while in SCRUB.
- ready_o  out  1  high when port requests are accepted; equals !scrub_busy_o.

Behaviour:
- Asynchronous reset values:
  - rdata_o = 0, rvalid_o = 0, all pipeline registers = 0.
  - Scrub counter = 0.
  - State = SCRUB if InitOnReset, else RUN.
  - scrub_busy_o = InitOnReset; ready_o = !InitOnReset.
- State SCRUB:
  - Each cycle writes all-zero to mem[cnt], then cnt++.
  - On the cycle cnt == Depth-1 is written, go to RUN and clear cnt. SCRUB therefore lasts exactly Depth cycles.
  - wreq_i and rreq_i are ignored: no memory change, no rvalid.
  - scrub_req_i is ignored.
- State RUN:
  - Write: wreq_i with waddr_i < Depth updates the groups whose mask bits are all 1. Groups with a zero mask keep their old value.
  - Read: rreq_i captures mem[raddr_i] at the clock edge.
    - OutputReg=0: rdata_o/rvalid_o are updated at edge N+1 after the request cycle N.
    - OutputReg=1: update at edge N+2.
  - Read-during-write at the same address in the same cycle: write-first. rdata_o returns the post-write word, with masked groups new and unmasked groups old.
  - Out-of-range addresses (addr >= Depth):
    - write: dropped;
    - read: rvalid_o pulses and rdata_o = 0.
  - No read request: rdata_o holds its last value and rvalid_o = 0.
  - scrub_req_i = 1 at an edge moves to SCRUB on the next cycle.
    - A write in that same cycle is still performed.
    - A read issued in that same cycle still completes: its rvalid appears during SCRUB with its data.
    - The scrub then overwrites the written word.
- Reset asserted during SCRUB or in-flight reads:
  - Pending reads are discarded.
  - The scrub restarts from address 0 after reset is released (InitOnReset=1).
- Assertion: on a write, each mask group within wmask_i is all-ones or all-zeros.
- Memory storage itself is not reset, only scrubbed. The model must remain elaboratable under the existing memory black-boxing synthesis macro.

Test Plan:
- Reset with Width=32, Depth=16, InitOnReset=1 -> scrub_busy_o=1 for exactly 16 cycles, then ready_o=1. A read of every address returns 0x00000000 with rvalid one cycle later.
- Write 0xDEADBEEF to addr 3, then read addr 3 (OutputReg=0) -> rdata_o=0xDEADBEEF and rvalid_o=1 at edge N+1. With OutputReg=1 -> the same values at edge N+2.
- addr 5 holds 0x11223344. Same-cycle write of 0xAABBCCDD to addr 5 with mask 0xFFFF0000, plus a read of addr 5 -> rdata_o=0xAABB3344.
- Write addr 7 = 0xCAFEF00D, then assert scrub_req_i for one cycle -> busy for 16 cycles, requests issued during busy are ignored, and addr 7 then reads 0.
- Reset asserted at scrub cycle 8 -> scrub restarts at address 0 and busy lasts a full 16 cycles after release.
- Depth=12: write 0x12345678 to addr 13, then read addr 13 -> rvalid_o=1 and rdata_o=0. Addresses 0-11 are unchanged.

Source files
------------

// File: rtl/prim_generic_ram_1r1w_scrub.sv
// prim_generic_ram_1r1w_scrub: simple-dual-port RAM with write-first forwarding, optional output register and zero-fill scrub
module prim_generic_ram_1r1w_scrub #(
  parameter int Width           = 32,
  parameter int Depth           = 128,
  parameter int DataBitsPerMask = 1,
  parameter int OutputReg       = 0,
  parameter int InitOnReset     = 1,
  localparam int Aw             = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wreq_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  input  logic             rreq_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o,
  output logic             rvalid_o,
  input  logic             scrub_req_i,
  output logic             scrub_busy_o,
  output logic             ready_o
);
  if (Width % DataBitsPerMask != 0) begin : g_bad_mask
    $error("Width must be a multiple of DataBitsPerMask");
  end
  typedef enum logic {SCRUB, RUN} state_e;
  localparam state_e ResetState = (InitOnReset != 0) ? SCRUB : RUN;
  localparam logic [Aw:0] DepthW = (Aw+1)'(Depth);
  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);
  state_e state_q, state_d;
  logic [Aw-1:0] cnt_q;
  logic [Width-1:0] mem [Depth];
  logic run, scrub_done, wr_en, rd_en, rd_inrange, rd_hit;
  logic [Width-1:0] wr_word, rd_word, rd_q;
  logic rv_q;
  assign run        = state_q == RUN;
  assign scrub_done = cnt_q == LastAddr;
  assign wr_en      = run && wreq_i && ({1'b0, waddr_i} < DepthW);
  assign rd_en      = run && rreq_i;
  assign rd_inrange = {1'b0, raddr_i} < DepthW;
  assign rd_hit     = wr_en && (waddr_i == raddr_i);
  assign wr_word    = (mem[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
  // Same-address read sees the merged post-write word; out-of-range reads return zero
  assign rd_word    = !rd_inrange ? '0 : rd_hit ? wr_word : mem[raddr_i];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ResetState;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = run ? (scrub_req_i ? SCRUB : RUN) : (scrub_done ? RUN : SCRUB);
  end
  always_comb begin
    scrub_busy_o = !run;
    ready_o      = run;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    cnt_q <= '0;
    else if (!run) cnt_q <= scrub_done ? '0 : cnt_q + Aw'(1);
  end
  // Storage is never reset; the scrub is the only way it gets a known value
  always_ff @(posedge clk_i) begin
    if (!run)       mem[cnt_q]   <= '0;
    else if (wr_en) mem[waddr_i] <= wr_word;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= rd_en;
      if (rd_en) rd_q <= rd_word;
    end
  end
  if (OutputReg != 0) begin : g_oreg
    logic [Width-1:0] rd2_q;
    logic rv2_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd2_q <= '0;
        rv2_q <= 1'b0;
      end else begin
        rv2_q <= rv_q;
        if (rv_q) rd2_q <= rd_q;
      end
    end
    assign rdata_o  = rd2_q;
    assign rvalid_o = rv2_q;
  end else begin : g_noreg
    assign rdata_o  = rd_q;
    assign rvalid_o = rv_q;
  end
`ifndef SYNTHESIS
  for (genvar g = 0; g < Width / DataBitsPerMask; g++) begin : g_mask_chk
    assert property (@(posedge clk_i) disable iff (rst_i)
      (run && wreq_i) |->
        (wmask_i[g*DataBitsPerMask +: DataBitsPerMask] == {DataBitsPerMask{1'b0}} ||
         wmask_i[g*DataBitsPerMask +: DataBitsPerMask] == {DataBitsPerMask{1'b1}}));
  end
`endif
endmodule
